// File: rtl/pulse_event_arbiter.sv
// Latches single-cycle request pulses and hands them out one at a time,
// round-robin, over a valid/ready handshake; flags overruns and counts transfers.
module pulse_event_arbiter #(
  parameter int N_REQ = 8,
  parameter int IDX_W = $clog2(N_REQ),
  parameter int CNT_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [N_REQ-1:0] i_Pulse,
  input  logic             i_Ready,
  output logic             o_Valid,
  output logic [IDX_W-1:0] o_Index,
  output logic [N_REQ-1:0] o_Pending,
  input  logic             i_Clr_Ovr,
  output logic             o_Overrun,
  output logic [CNT_W-1:0] o_Event_Count
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   pending_reg, pending_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic               ovr_reg, ovr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               xfer;
  logic [N_REQ-1:0]   xfer_mask;
  logic [IDX_W-1:0]   rr_pick;

  assign xfer = (state_reg == OFFER) && i_Ready;

  // One-hot of the index being retired on this edge (all zero when no transfer).
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_xfer_mask
      assign xfer_mask[gi] = xfer && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    logic [IDX_W:0] sum;
    sum     = '0;
    rr_pick = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      sum = {1'b0, ptr_reg} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N_REQ))
        sum = sum - (IDX_W+1)'(N_REQ);
      if (pending_reg[sum[IDX_W-1:0]])
        rr_pick = sum[IDX_W-1:0];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      idx_reg     <= '0;
      ptr_reg     <= IDX_W'(N_REQ - 1);
      ovr_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      idx_reg     <= idx_next;
      ptr_reg     <= ptr_next;
      ovr_reg     <= ovr_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    // A pulse on the index being retired re-queues it instead of overrunning.
    pending_next = (pending_reg & ~xfer_mask) | i_Pulse;
    ovr_next     = (|(i_Pulse & pending_reg & ~xfer_mask)) | (ovr_reg & ~i_Clr_Ovr);
    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          state_next = OFFER;
          idx_next   = rr_pick;
        end
      end
      OFFER: begin
        if (i_Ready) begin
          state_next = IDLE;
          ptr_next   = idx_reg;
          cnt_next   = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_Valid = (state_reg == OFFER);
  end

  assign o_Index       = idx_reg;
  assign o_Pending     = pending_reg;
  assign o_Overrun     = ovr_reg;
  assign o_Event_Count = cnt_reg;

endmodule
